// File: rtl/burst_sender_pkg.sv
// Shared types and widths for the burst sender: FSM state encoding and default field sizes.
package burst_sender_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_LEN_WIDTH  = 8;
  localparam int unsigned STALL_CNT_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/burst_sender.sv
// Expands a {base, len} command into len incrementing words pushed to a downstream FIFO,
// marking the final word, pulsing done_o at completion and counting grant stalls.
module burst_sender
  import burst_sender_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [DATA_WIDTH-1:0]      cmd_base_i,
  input  logic [LEN_WIDTH-1:0]       cmd_len_i,
  output logic                       push_valid_o,
  output logic [DATA_WIDTH:0]        push_data_o,
  input  logic                       push_grant_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

  localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  idx_q;

  logic [LEN_WIDTH-1:0]  idx_nxt_c;
  logic                  last_nxt_c;

  // Word after the current one; its last flag is precomputed so push_data_o stays registered.
  assign idx_nxt_c  = idx_q + LEN_WIDTH'(1);
  assign last_nxt_c = (idx_nxt_c == (len_q - LEN_WIDTH'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      cmd_ready_o  <= 1'b1;
      push_valid_o <= 1'b0;
      push_data_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      stall_cnt_o  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            base_q      <= cmd_base_i;
            len_q       <= cmd_len_i;
            idx_q       <= '0;
            stall_cnt_o <= '0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (cmd_len_i != '0) begin
              state_q      <= SEND;
              push_valid_o <= 1'b1;
              push_data_o  <= {(cmd_len_i == LEN_WIDTH'(1)), cmd_base_i};
            end else begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end
          end
        end

        SEND: begin
          if (push_grant_i) begin
            if (push_data_o[DATA_WIDTH]) begin
              state_q      <= DONE;
              push_valid_o <= 1'b0;
              push_data_o  <= '0;
              done_o       <= 1'b1;
            end else begin
              idx_q       <= idx_nxt_c;
              push_data_o <= {last_nxt_c, base_q + DATA_WIDTH'(idx_nxt_c)};
            end
          end else if (stall_cnt_o != STALL_MAX) begin
            stall_cnt_o <= stall_cnt_o + STALL_CNT_WIDTH'(1);
          end
        end

        DONE: begin
          state_q     <= IDLE;
          done_o      <= 1'b0;
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
        end

        default: begin
          state_q      <= IDLE;
          push_valid_o <= 1'b0;
          done_o       <= 1'b0;
          busy_o       <= 1'b0;
          cmd_ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_sender.sv
// Directed bench for burst_sender: per-cycle vector table plus reset and FIFO back-pressure sequences.
module tb_burst_sender;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_base_i;
  logic [7:0]  cmd_len_i;
  logic        push_valid_o;
  logic [32:0] push_data_o;
  logic        push_grant_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;
  logic [32:0] xfer_q[$];

  burst_sender dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_base_i   (cmd_base_i),
    .cmd_len_i    (cmd_len_i),
    .push_valid_o (push_valid_o),
    .push_data_o  (push_data_o),
    .push_grant_i (push_grant_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every transfer as seen at the active edge.
  always @(posedge clk) begin
    if (rst_n && push_valid_o && push_grant_i) xfer_q.push_back(push_data_o);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        cv;
    logic [31:0] base;
    logic [7:0]  len;
    logic        gnt;
    logic        ev;
    logic [32:0] ed;
    logic        edone;
    logic        erdy;
    logic        ebusy;
    logic [15:0] estall;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];
  int   xs[NV];

  initial begin
    int x0;
    int popped;
    int cnt;
    int budget;
    bit saw_done;
    logic [32:0] exp_w;

    // Rows: expected outputs seen at this negedge, then inputs driven for the next edge.
    vecs[0]  = '{1'b1, 32'h10, 8'd3, 1'b1, 1'b0, 33'h0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b1, 33'h0_00000010, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[2]  = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b1, 33'h0_00000011, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[3]  = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b1, 33'h1_00000012, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[4]  = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b0, 33'h0, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[5]  = '{1'b1, 32'h10, 8'd3, 1'b1, 1'b0, 33'h0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b1, 33'h0_00000010, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[7]  = '{1'b0, 32'h0, 8'd0, 1'b0, 1'b1, 33'h0_00000011, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[8]  = '{1'b0, 32'h0, 8'd0, 1'b0, 1'b1, 33'h0_00000011, 1'b0, 1'b0, 1'b1, 16'd1};
    vecs[9]  = '{1'b0, 32'h0, 8'd0, 1'b0, 1'b1, 33'h0_00000011, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[10] = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b1, 33'h0_00000011, 1'b0, 1'b0, 1'b1, 16'd3};
    vecs[11] = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b1, 33'h1_00000012, 1'b0, 1'b0, 1'b1, 16'd3};
    vecs[12] = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b0, 33'h0, 1'b1, 1'b0, 1'b1, 16'd3};
    vecs[13] = '{1'b1, 32'hFFFFFFFE, 8'd3, 1'b1, 1'b0, 33'h0, 1'b0, 1'b1, 1'b0, 16'd3};
    vecs[14] = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b1, 33'h0_FFFFFFFE, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[15] = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b1, 33'h0_FFFFFFFF, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[16] = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b1, 33'h1_00000000, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[17] = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b0, 33'h0, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[18] = '{1'b1, 32'h55, 8'd0, 1'b1, 1'b0, 33'h0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[19] = '{1'b1, 32'h99, 8'd2, 1'b1, 1'b0, 33'h0, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[20] = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b0, 33'h0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[21] = '{1'b0, 32'h0, 8'd0, 1'b1, 1'b0, 33'h0, 1'b0, 1'b1, 1'b0, 16'd0};

    rst_n = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_base_i = '0;
    cmd_len_i = '0;
    push_grant_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(push_valid_o), 64'd0);
    check("rst_data",  64'(push_data_o),  64'd0);
    check("rst_ready", 64'(cmd_ready_o),  64'd1);
    check("rst_busy",  64'(busy_o),       64'd0);
    check("rst_done",  64'(done_o),       64'd0);
    check("rst_stall", 64'(stall_cnt_o),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      xs[i] = xfer_q.size();
      check($sformatf("v%0d_valid", i), 64'(push_valid_o), 64'(vecs[i].ev));
      if (vecs[i].ev) check($sformatf("v%0d_data", i), 64'(push_data_o), 64'(vecs[i].ed));
      check($sformatf("v%0d_done", i),  64'(done_o),      64'(vecs[i].edone));
      check($sformatf("v%0d_ready", i), 64'(cmd_ready_o), 64'(vecs[i].erdy));
      check($sformatf("v%0d_busy", i),  64'(busy_o),      64'(vecs[i].ebusy));
      check($sformatf("v%0d_stall", i), 64'(stall_cnt_o), 64'(vecs[i].estall));
      cmd_valid_i  = vecs[i].cv;
      cmd_base_i   = vecs[i].base;
      cmd_len_i    = vecs[i].len;
      push_grant_i = vecs[i].gnt;
      @(negedge clk);
    end
    check("xfers_burst1",  64'(xs[5] - xs[0]),  64'd3);
    check("xfers_stalled", 64'(xs[13] - xs[5]), 64'd3);
    check("xfers_len0",    64'(xs[21] - xs[18]), 64'd0);

    // Reset in the middle of a len=5 burst after two transfers.
    cmd_valid_i = 1'b1; cmd_base_i = 32'h20; cmd_len_i = 8'd5; push_grant_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_data_before_rst", 64'(push_data_o), 64'h0_00000022);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(push_valid_o), 64'd0);
    check("mid_rst_done",  64'(done_o),       64'd0);
    check("mid_rst_ready", 64'(cmd_ready_o),  64'd1);
    check("mid_rst_busy",  64'(busy_o),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", 64'(done_o), 64'd0);
    cmd_valid_i = 1'b1; cmd_base_i = 32'h33; cmd_len_i = 8'd1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("len1_valid", 64'(push_valid_o), 64'd1);
    check("len1_data",  64'(push_data_o),  64'h1_00000033);
    @(negedge clk);
    check("len1_done",  64'(done_o),       64'd1);
    check("len1_valid_off", 64'(push_valid_o), 64'd0);
    @(negedge clk);

    // Depth-4 FIFO downstream with the pop side initially stalled.
    x0 = xfer_q.size();
    popped = 0;
    saw_done = 1'b0;
    cmd_valid_i = 1'b1; cmd_base_i = 32'h40; cmd_len_i = 8'd6; push_grant_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cnt = xfer_q.size() - x0 - popped;
      push_grant_i = (cnt < 4);
      @(negedge clk);
    end
    check("fifo_fill_cnt",  64'(xfer_q.size() - x0), 64'd4);
    check("fifo_hold_valid", 64'(push_valid_o), 64'd1);
    check("fifo_hold_grant", 64'(push_grant_i), 64'd0);
    check("fifo_hold_data",  64'(push_data_o),  64'h0_00000044);
    check("fifo_stall_cnt",  64'(stall_cnt_o),  64'd6);
    budget = 40;
    while (popped < 6 && budget > 0) begin
      if (done_o) saw_done = 1'b1;
      cnt = xfer_q.size() - x0 - popped;
      if (cnt > 0) begin
        exp_w = {(popped == 5), 32'h40 + 32'(popped)};
        check($sformatf("fifo_pop%0d", popped), 64'(xfer_q[x0 + popped]), 64'(exp_w));
        popped++;
        cnt--;
      end
      push_grant_i = (cnt < 4);
      @(negedge clk);
      budget--;
    end
    if (done_o) saw_done = 1'b1;
    check("fifo_all_popped", 64'(popped), 64'd6);
    check("fifo_done_seen",  64'(saw_done), 64'd1);
    check("fifo_total_xfers", 64'(xfer_q.size() - x0), 64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
